// File: rtl/rd_port_arbiter.sv
// Shares one read-address/read-data port between NUM_REQ requesters: round-robin
// address capture into a single output register, in-order tag FIFO routes responses back.
module rd_port_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                           clk_i,
  input  logic                           arst_ni,
  input  logic [NUM_REQ*ADDR_W-1:0]      req_addr_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  output logic [ADDR_W-1:0]              rd_addr_o,
  output logic                           rd_addr_valid_o,
  input  logic                           rd_addr_ready_i,
  input  logic [DATA_W-1:0]              rd_data_i,
  input  logic                           rd_data_valid_i,
  output logic [DATA_W-1:0]              rsp_data_o,
  output logic [NUM_REQ-1:0]             rsp_valid_o,
  output logic [$clog2(MAX_OUTST+1)-1:0] outstanding_o,
  output logic                           err_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CNT_W = $clog2(MAX_OUTST+1);

  logic [IDX_W-1:0]  rr_ptr_r;
  logic [IDX_W-1:0]  tag_mem_r [MAX_OUTST];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [ADDR_W-1:0] rd_addr_r;
  logic              rd_addr_valid_r;
  logic              err_r;

  logic              win_found_s;
  logic [IDX_W-1:0]  win_idx_s;
  logic [IDX_W-1:0]  cand_s;
  logic              slot_free_s;
  logic              capture_s;
  logic              pop_s;

  function automatic logic [NUM_REQ-1:0] to_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

  // Round-robin search starting at rr_ptr_r; the first valid requester wins.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    cand_s      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s      = IDX_W'((int'(rr_ptr_r) + k) % NUM_REQ);
      win_idx_s   = (!win_found_s && req_valid_i[cand_s]) ? cand_s : win_idx_s;
      win_found_s = win_found_s | req_valid_i[cand_s];
    end
  end

  // Credit check uses the registered count, so a full FIFO blocks capture even on a pop cycle.
  assign slot_free_s = !rd_addr_valid_r || rd_addr_ready_i;
  assign capture_s   = slot_free_s && (count_r < CNT_W'(MAX_OUTST)) && win_found_s;
  assign pop_s       = rd_data_valid_i && (count_r != {CNT_W{1'b0}});

  assign req_ready_o     = capture_s ? to_onehot(win_idx_s) : {NUM_REQ{1'b0}};
  assign rsp_valid_o     = pop_s ? to_onehot(tag_mem_r[rd_ptr_r]) : {NUM_REQ{1'b0}};
  assign rsp_data_o      = rd_data_i;
  assign rd_addr_o       = rd_addr_r;
  assign rd_addr_valid_o = rd_addr_valid_r;
  assign outstanding_o   = count_r;
  assign err_o           = err_r;

  // Output address register and round-robin pointer.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      rd_addr_r       <= {ADDR_W{1'b0}};
      rd_addr_valid_r <= 1'b0;
      rr_ptr_r        <= {IDX_W{1'b0}};
    end else if (capture_s) begin
      rd_addr_r       <= req_addr_i[int'(win_idx_s)*ADDR_W +: ADDR_W];
      rd_addr_valid_r <= 1'b1;
      rr_ptr_r        <= IDX_W'((int'(win_idx_s) + 1) % NUM_REQ);
    end else if (rd_addr_valid_r && rd_addr_ready_i) begin
      rd_addr_valid_r <= 1'b0;
    end else begin
      rd_addr_valid_r <= rd_addr_valid_r;
    end
  end

  // Tag FIFO, occupancy count and sticky orphan-data flag.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int i = 0; i < MAX_OUTST; i++) begin
        tag_mem_r[i] <= {IDX_W{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      err_r    <= 1'b0;
    end else begin
      if (capture_s) begin
        tag_mem_r[wr_ptr_r] <= win_idx_s;
        wr_ptr_r            <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({capture_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (rd_data_valid_i && (count_r == {CNT_W{1'b0}})) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

endmodule

// File: tb/tb_rd_port_arbiter.sv
// Directed bench for rd_port_arbiter (NUM_REQ=2, MAX_OUTST=4): inputs driven 1 time unit
// after the rising edge, all outputs sampled 1 unit later.
module tb_rd_port_arbiter;

  logic        clk;
  logic        arst_ni;
  logic [63:0] req_addr;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] rd_addr;
  logic        rd_addr_valid;
  logic        rd_addr_ready;
  logic [31:0] rd_data;
  logic        rd_data_valid;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_valid;
  logic [2:0]  outstanding;
  logic        err;

  int total = 0;
  int bad   = 0;

  // Fairness table: per-cycle stimulus and expectations (pointer starts at 1 here).
  logic [1:0]  f_val  [6] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
  logic [1:0]  f_rdy  [6] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b00, 2'b00};
  logic        f_dv   [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [31:0] f_data [6] = '{32'h0, 32'h0, 32'h11, 32'h22, 32'h33, 32'h44};
  logic [1:0]  f_rsp  [6] = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b10, 2'b01};
  logic        f_av   [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [31:0] f_addr [6] = '{32'h0, 32'h2000, 32'h1000, 32'h2000, 32'h1000, 32'h0};
  logic [31:0] f_cnt  [6] = '{32'd0, 32'd1, 32'd2, 32'd2, 32'd2, 32'd1};
  logic [1:0]  c_rdy  [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [1:0]  c_rsp  [4] = '{2'b10, 2'b01, 2'b10, 2'b01};

  rd_port_arbiter #(
    .NUM_REQ(2), .ADDR_W(32), .DATA_W(32), .MAX_OUTST(4)
  ) dut (
    .clk_i          (clk),
    .arst_ni        (arst_ni),
    .req_addr_i     (req_addr),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .rd_addr_o      (rd_addr),
    .rd_addr_valid_o(rd_addr_valid),
    .rd_addr_ready_i(rd_addr_ready),
    .rd_data_i      (rd_data),
    .rd_data_valid_i(rd_data_valid),
    .rsp_data_o     (rsp_data),
    .rsp_valid_o    (rsp_valid),
    .outstanding_o  (outstanding),
    .err_o          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    arst_ni       = 1'b0;
    req_addr      = 64'h0;
    req_valid     = 2'b00;
    rd_addr_ready = 1'b0;
    rd_data       = 32'h0;
    rd_data_valid = 1'b0;
    #2;
    chk("rst_addr_valid", 32'(rd_addr_valid), 32'h0);
    chk("rst_addr", rd_addr, 32'h0);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_outstanding", 32'(outstanding), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    tick();
    arst_ni = 1'b1;
    tick();

    // Single request from requester 0.
    req_valid = 2'b01; req_addr[31:0] = 32'h100; rd_addr_ready = 1'b1;
    #1 chk("single_grant", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    #1;
    chk("single_addr", rd_addr, 32'h100);
    chk("single_addr_valid", 32'(rd_addr_valid), 32'h1);
    chk("single_outst1", 32'(outstanding), 32'h1);
    tick();
    chk("single_addr_clear", 32'(rd_addr_valid), 32'h0);
    rd_data_valid = 1'b1; rd_data = 32'hAA;
    #1;
    chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("single_rsp_data", rsp_data, 32'hAA);
    tick();
    rd_data_valid = 1'b0;
    #1 chk("single_outst0", 32'(outstanding), 32'h0);

    // Fairness with responses two cycles after each grant.
    req_addr = {32'h2000, 32'h1000};
    for (int c = 0; c < 6; c++) begin
      req_valid = f_val[c]; rd_data_valid = f_dv[c]; rd_data = f_data[c];
      #1;
      chk($sformatf("fair_grant_c%0d", c), 32'(req_ready), 32'(f_rdy[c]));
      chk($sformatf("fair_rsp_c%0d", c), 32'(rsp_valid), 32'(f_rsp[c]));
      chk($sformatf("fair_av_c%0d", c), 32'(rd_addr_valid), 32'(f_av[c]));
      chk($sformatf("fair_cnt_c%0d", c), 32'(outstanding), f_cnt[c]);
      if (f_av[c]) chk($sformatf("fair_addr_c%0d", c), rd_addr, f_addr[c]);
      if (f_dv[c]) chk($sformatf("fair_data_c%0d", c), rsp_data, f_data[c]);
      tick();
    end
    rd_data_valid = 1'b0; req_valid = 2'b00;
    #1 chk("fair_drained", 32'(outstanding), 32'h0);

    // Backpressure: 0x200 held while downstream stalls.
    rd_addr_ready = 1'b0; req_valid = 2'b01; req_addr = {32'h300, 32'h200};
    #1 chk("bp_grant0", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b10;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp_hold_addr_%0d", c), rd_addr, 32'h200);
      chk($sformatf("bp_hold_valid_%0d", c), 32'(rd_addr_valid), 32'h1);
      chk($sformatf("bp_no_grant_%0d", c), 32'(req_ready), 32'h0);
      tick();
    end
    rd_addr_ready = 1'b1;
    #1;
    chk("bp_release_grant", 32'(req_ready), 32'h2);
    chk("bp_release_addr", rd_addr, 32'h200);
    tick();
    req_valid = 2'b00;
    #1;
    chk("bp_next_addr", rd_addr, 32'h300);
    chk("bp_outst2", 32'(outstanding), 32'h2);
    tick();
    chk("bp_one_handshake", 32'(rd_addr_valid), 32'h0);
    rd_data_valid = 1'b1; rd_data = 32'h55;
    #1 chk("bp_rsp0", 32'(rsp_valid), 32'h1);
    tick();
    rd_data = 32'h66;
    #1 chk("bp_rsp1", 32'(rsp_valid), 32'h2);
    tick();
    rd_data_valid = 1'b0;
    #1 chk("bp_drained", 32'(outstanding), 32'h0);

    // Credit limit: four captures, then blocked until a pop has been registered.
    req_valid = 2'b11; req_addr = {32'h500, 32'h400};
    for (int c = 0; c < 4; c++) begin
      #1 chk($sformatf("cred_grant_%0d", c), 32'(req_ready), 32'(c_rdy[c]));
      tick();
    end
    #1;
    chk("cred_full_block", 32'(req_ready), 32'h0);
    chk("cred_full_cnt", 32'(outstanding), 32'h4);
    tick();
    rd_data_valid = 1'b1; rd_data = 32'h77;
    #1;
    chk("cred_pop_first", 32'(rsp_valid), 32'h1);
    chk("cred_pop_block", 32'(req_ready), 32'h0);
    tick();
    rd_data_valid = 1'b0;
    #1;
    chk("cred_cnt3", 32'(outstanding), 32'h3);
    chk("cred_resume", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    #1 chk("cred_cnt4_again", 32'(outstanding), 32'h4);
    rd_data_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1 chk($sformatf("cred_drain_%0d", c), 32'(rsp_valid), 32'(c_rsp[c]));
      tick();
    end
    rd_data_valid = 1'b0;
    #1 chk("cred_drained", 32'(outstanding), 32'h0);

    // Orphan data with nothing outstanding.
    rd_data_valid = 1'b1; rd_data = 32'h99;
    #1;
    chk("orph_no_rsp", 32'(rsp_valid), 32'h0);
    chk("orph_data", rsp_data, 32'h99);
    chk("orph_err_before", 32'(err), 32'h0);
    tick();
    rd_data_valid = 1'b0;
    #1 chk("orph_err_set", 32'(err), 32'h1);
    repeat (10) tick();
    chk("orph_err_sticky", 32'(err), 32'h1);

    // Reset mid-flight with three reads outstanding (pointer is 1 here).
    req_valid = 2'b11;
    #1 chk("rmf_grant0", 32'(req_ready), 32'h2);
    tick();
    #1 chk("rmf_grant1", 32'(req_ready), 32'h1);
    tick();
    #1 chk("rmf_grant2", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b00;
    #1 chk("rmf_outst3", 32'(outstanding), 32'h3);
    arst_ni = 1'b0;
    #1;
    chk("rmf_addr_valid", 32'(rd_addr_valid), 32'h0);
    chk("rmf_addr", rd_addr, 32'h0);
    chk("rmf_outst0", 32'(outstanding), 32'h0);
    chk("rmf_err_clr", 32'(err), 32'h0);
    chk("rmf_rsp_valid", 32'(rsp_valid), 32'h0);
    tick();
    arst_ni = 1'b1;
    #1;
    req_valid = 2'b11;
    #1 chk("rmf_ptr0", 32'(req_ready), 32'h1);
    req_valid = 2'b00;
    rd_data_valid = 1'b1; rd_data = 32'hBB;
    #1 chk("rmf_orphan_rsp", 32'(rsp_valid), 32'h0);
    tick();
    rd_data_valid = 1'b0;
    #1 chk("rmf_orphan_err", 32'(err), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rd_port_arbiter.md
Name: rd_port_arbiter

Overview:
- Shares the single operand read-address/read-data port between NUM_REQ requesters, e.g. several operand controllers or address FSMs.
- Arbitrates read-address requests round-robin into a registered single-entry output stage.
- Records the grantee of every issued address in an in-order tag FIFO.
- Routes each returning read-data beat back to the requester that issued it.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 32, read-address width (matches addr_t)
DATA_W, 32, read-data width (matches data_t)
MAX_OUTST, 4, maximum reads captured but not yet answered; tag FIFO depth (power of 2, >=2)

Ports:
clk_i  in  1  clock
arst_ni  in  1  asynchronous active-low reset
req_addr_i  in  NUM_REQ*ADDR_W  request addresses, requester i at slice [i*ADDR_W +: ADDR_W]
req_valid_i  in  NUM_REQ  request valid per requester
req_ready_o  out  NUM_REQ  request accepted this cycle, one-hot or zero
rd_addr_o  out  ADDR_W  shared read address
rd_addr_valid_o  out  1  shared read address valid
rd_addr_ready_i  in  1  downstream accepts address
rd_data_i  in  DATA_W  returning read data, in issue order, no backpressure
rd_data_valid_i  in  1  read data valid
rsp_data_o  out  DATA_W  read data broadcast to all requesters
rsp_valid_o  out  NUM_REQ  one-hot response valid to the owning requester
outstanding_o  out  $clog2(MAX_OUTST+1)  current outstanding count
err_o  out  1  sticky: read data arrived with no outstanding tag

Behaviour:
- Reset (async, arst_ni=0):
  - rd_addr_valid_o=0, rd_addr_o=0, req_ready_o=0, rsp_valid_o=0, outstanding_o=0, err_o=0.
  - Tag FIFO emptied; round-robin pointer=0.
  - Deassertion mid-transaction drops all in-flight state. Data returning afterwards counts as an orphan: dropped, err_o=1.
- Output stage:
  - One register pair, rd_addr_o/rd_addr_valid_o.
  - "slot_free" = !rd_addr_valid_o || rd_addr_ready_i.
  - While rd_addr_valid_o=1 and rd_addr_ready_i=0, rd_addr_o is held stable.
- Capture condition: slot_free && (outstanding_o < MAX_OUTST) && |req_valid_i. The outstanding_o comparison uses the registered value.
- Arbitration (combinational, same cycle):
  - Search from pointer ptr upward, wrapping mod NUM_REQ. The first i with req_valid_i[i]=1 wins.
  - req_ready_o[i]=1 only for the winner, and only when the capture condition holds; otherwise all zero.
- On capture (edge at end of cycle N):
  - rd_addr_o <= winner's address and rd_addr_valid_o <= 1, visible in cycle N+1.
  - Winner index pushed to the tag FIFO.
  - ptr <= (winner+1) mod NUM_REQ.
- Without a capture:
  - A handshake (rd_addr_valid_o && rd_addr_ready_i) clears rd_addr_valid_o.
  - ptr is unchanged.
- Back-to-back: a handshake in cycle N and a capture in cycle N together keep rd_addr_valid_o=1 with the new address. Full throughput is 1 address/cycle.
- Requester rule: a requester must hold req_valid_i/req_addr_i until it sees req_ready_o. The block does not check this.
- Response path (zero latency, combinational):
  - When rd_data_valid_i=1 and the FIFO is non-empty, rsp_valid_o = onehot(FIFO head), rsp_data_o = rd_data_i, and the head is popped.
  - When rd_data_valid_i=1 and the FIFO is empty, rsp_valid_o=0 and err_o<=1, which stays set until reset.
  - rsp_data_o = rd_data_i at all times.
- Counter:
  - outstanding_o equals tag FIFO occupancy: +1 on capture, -1 on a valid pop, unchanged when both occur in the same cycle.
  - Never exceeds MAX_OUTST.
  - At full, capture is blocked even if a response pops in the same cycle; capture resumes the next cycle.
- FIFO pointers wrap mod MAX_OUTST, with a separate count distinguishing full from empty.

Test Plan:
- Single request: NUM_REQ=2, req_valid_i=01, addr 0x100, rd_addr_ready_i=1. Expect req_ready_o=01 in cycle 0, rd_addr_o=0x100 with valid in cycle 1. Then rd_data 0xAA → rsp_valid_o=01, rsp_data_o=0xAA, outstanding_o returns 0.
- Fairness: both requesters valid continuously, ready=1, responses 2 cycles later. Expect grants alternate 0,1,0,1. Addresses issued every cycle; each response goes to the matching requester in order.
- Backpressure: rd_addr_ready_i=0 for 5 cycles with addr 0x200 pending. Expect rd_addr_o held at 0x200, valid held, req_ready_o=0 while the slot is occupied. Exactly one handshake follows when ready=1.
- Credit limit: MAX_OUTST=4, no responses. Expect exactly 4 captures, then req_ready_o=0 and outstanding_o=4. One response → rsp_valid_o to the first grantee; next cycle outstanding_o=3, with a capture allowed the cycle after.
- Orphan: rd_data_valid_i=1 with no outstanding reads → rsp_valid_o=0, err_o=1 and still 1 after 10 idle cycles.
- Reset mid-flight: 3 outstanding reads, pulse arst_ni low for 1 cycle. Expect all outputs 0 and ptr=0. A subsequent rd_data_valid_i → err_o=1.
